// File: rtl/muldiv_hilo_ctrl_if.sv
// EX-stage handshake between the pipeline and the multiply/divide engine.
// master = pipeline side (EX/ID decode and hazard logic), slave = engine.
interface muldiv_hilo_ctrl_if;
  logic        op_valid;
  logic [2:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        id_uses_md;
  logic        hilo_sel;
  logic        busy;
  logic        stall;
  logic [31:0] hilo_rd;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output op_valid, md_op, rs_val, rt_val, id_uses_md, hilo_sel,
    input  busy, stall, hilo_rd, hi, lo
  );

  modport slave (
    input  op_valid, md_op, rs_val, rt_val, id_uses_md, hilo_sel,
    output busy, stall, hilo_rd, hi, lo
  );
endinterface

// File: rtl/muldiv_hilo_ctrl.sv
// Multi-cycle mult/div engine and HI/LO register owner for the MIPS EX stage.
// Ops run a fixed cycle count from latched operands; HI/LO update on the last edge.
module muldiv_hilo_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic                clk,
  input  logic                rst,
  muldiv_hilo_ctrl_if.slave   md
);

  localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [2:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [63:0] res_d;
  logic        start_d;

  // Returns {hi, lo} for the latched operation, including the MIPS corner cases.
  function automatic logic [63:0] md_result(input logic [2:0]  op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic signed [31:0] sxa;
    logic signed [31:0] sxb;
    logic signed [31:0] sq;
    logic signed [31:0] sr;
    logic [63:0]        r;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    sxa = a;
    sxb = b;
    sq  = '0;
    sr  = '0;
    r   = '0;
    case (op)
      3'd0: r = sa * sb;
      3'd1: r = {32'd0, a} * {32'd0, b};
      3'd2: begin
        if (b == 32'd0) begin
          r = {a, 32'hFFFF_FFFF};
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          r = {32'd0, 32'h8000_0000};
        end else begin
          sq = sxa / sxb;
          sr = sxa % sxb;
          r  = {sr, sq};
        end
      end
      3'd3: begin
        if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
        else            r = {a % b, a / b};
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  always_comb begin
    res_d = md_result(op_q, a_q, b_q);
  end

  assign start_d    = md.op_valid & ~md.md_op[2];
  assign md.busy    = (state_q == BUSY);
  assign md.stall   = md.id_uses_md & (md.busy | (start_d & (state_q == IDLE)));
  assign md.hilo_rd = md.hilo_sel ? lo_q : hi_q;
  assign md.hi      = hi_q;
  assign md.lo      = lo_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (md.op_valid) begin
            case (md.md_op)
              3'd0, 3'd1, 3'd2, 3'd3: begin
                op_q    <= md.md_op;
                a_q     <= md.rs_val;
                b_q     <= md.rt_val;
                cnt_q   <= md.md_op[1] ? DIV_N : MULT_N;
                state_q <= BUSY;
              end
              3'd4:    hi_q <= md.rs_val;
              3'd5:    lo_q <= md.rs_val;
              default: ;
            endcase
          end
        end
        BUSY: begin
          cnt_q <= cnt_q - 4'd1;
          // Treat a zero count as final too, so the FSM can never wedge in BUSY.
          if (cnt_q <= 4'd1) begin
            hi_q    <= res_d[63:32];
            lo_q    <= res_d[31:0];
            cnt_q   <= '0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Bench for muldiv_hilo_ctrl: expected HI/LO pairs are queued at issue and
// compared when the engine drops busy; stall and HI/LO writes checked per cycle.
module tb_muldiv_hilo_ctrl;

  localparam int MC = 5;
  localparam int DC = 10;

  logic clk;
  logic rst;
  int   checks;
  int   fails;
  logic [63:0] sb_q[$];

  muldiv_hilo_ctrl_if bus ();

  muldiv_hilo_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk (clk),
    .rst (rst),
    .md  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Signed product via magnitudes, independent of signed operators.
  function automatic logic [63:0] smul_model(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ua;
    logic [31:0] ub;
    logic [63:0] p;
    ua = a[31] ? (~a + 32'd1) : a;
    ub = b[31] ? (~b + 32'd1) : b;
    p  = {32'd0, ua} * {32'd0, ub};
    return (a[31] ^ b[31]) ? (~p + 64'd1) : p;
  endfunction

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int n, input logic use_md);
    int cnt;
    logic [63:0] exp_v;
    logic [63:0] got;
    @(negedge clk);
    bus.op_valid   = 1'b1;
    bus.md_op      = op;
    bus.rs_val     = a;
    bus.rt_val     = b;
    bus.id_uses_md = use_md;
    #1;
    checks++;
    if (bus.stall !== use_md) begin
      fails++;
      $display("FAIL %s start_stall got=%b want=%b", name, bus.stall, use_md);
    end
    @(negedge clk);
    bus.op_valid = 1'b0;
    bus.md_op    = 3'd6;
    bus.rs_val   = $urandom;
    bus.rt_val   = $urandom;
    cnt = 0;
    while (bus.busy === 1'b1 && cnt < 40) begin
      checks++;
      if (bus.stall !== use_md) begin
        fails++;
        $display("FAIL %s busy_stall cycle=%0d got=%b want=%b", name, cnt + 1, bus.stall, use_md);
      end
      cnt++;
      @(negedge clk);
    end
    checks++;
    if (cnt != n) begin
      fails++;
      $display("FAIL %s busy_cycles got=%0d want=%0d", name, cnt, n);
    end
    checks++;
    if (bus.stall !== 1'b0) begin
      fails++;
      $display("FAIL %s stall_after got=%b want=0", name, bus.stall);
    end
    checks++;
    if (sb_q.size() == 0) begin
      fails++;
      $display("FAIL %s scoreboard_empty got=none want=entry", name);
    end else begin
      exp_v = sb_q.pop_front();
      got   = {bus.hi, bus.lo};
      if (got !== exp_v) begin
        fails++;
        $display("FAIL %s hilo got=%h want=%h", name, got, exp_v);
      end
    end
    bus.id_uses_md = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    bus.id_uses_md = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.stall !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctrl got busy=%b stall=%b want 0/0", bus.busy, bus.stall);
    end
    checks++;
    if (bus.hi !== 32'd0 || bus.lo !== 32'd0 || bus.hilo_rd !== 32'd0) begin
      fails++;
      $display("FAIL reset_hilo got hi=%h lo=%h rd=%h want 0", bus.hi, bus.lo, bus.hilo_rd);
    end
    bus.id_uses_md = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_mult();
    sb_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFA});
    run_op("mult_neg2x3", 3'd0, 32'hFFFF_FFFE, 32'd3, MC, 1'b0);
    sb_q.push_back({32'h0000_0001, 32'hFFFF_FFFE});
    run_op("multu_max_x2", 3'd1, 32'hFFFF_FFFF, 32'd2, MC, 1'b0);
  endtask

  task automatic test_div();
    sb_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_op("div_m7_2", 3'd2, 32'hFFFF_FFF9, 32'd2, DC, 1'b0);
    sb_q.push_back({32'd1, 32'hFFFF_FFFD});
    run_op("div_7_m2", 3'd2, 32'd7, 32'hFFFF_FFFE, DC, 1'b0);
    sb_q.push_back({32'd7, 32'hFFFF_FFFF});
    run_op("divu_by0", 3'd3, 32'd7, 32'd0, DC, 1'b0);
    sb_q.push_back({32'hFFFF_FFFB, 32'hFFFF_FFFF});
    run_op("div_by0", 3'd2, 32'hFFFF_FFFB, 32'd0, DC, 1'b0);
    sb_q.push_back({32'd0, 32'h8000_0000});
    run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, DC, 1'b0);
  endtask

  task automatic test_hazard();
    sb_q.push_back({32'd1, 32'd33});
    run_op("hazard_div", 3'd2, 32'd100, 32'd3, DC, 1'b1);
    sb_q.push_back({32'd2, 32'd16});
    run_op("nohazard_div", 3'd3, 32'd50, 32'd3, DC, 1'b0);
  endtask

  task automatic test_mthi_mtlo();
    @(negedge clk);
    bus.op_valid = 1'b1;
    bus.md_op    = 3'd4;
    bus.rs_val   = 32'h1234_5678;
    @(negedge clk);
    checks++;
    if (bus.hi !== 32'h1234_5678 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL mthi got hi=%h busy=%b want 12345678/0", bus.hi, bus.busy);
    end
    bus.md_op  = 3'd5;
    bus.rs_val = 32'h9ABC_DEF0;
    @(negedge clk);
    checks++;
    if (bus.lo !== 32'h9ABC_DEF0 || bus.hi !== 32'h1234_5678 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL mtlo got hi=%h lo=%h busy=%b want 12345678/9abcdef0/0", bus.hi, bus.lo, bus.busy);
    end
    bus.md_op  = 3'd7;
    bus.rs_val = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.op_valid = 1'b0;
    checks++;
    if (bus.hi !== 32'h1234_5678 || bus.lo !== 32'h9ABC_DEF0 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL noop7 got hi=%h lo=%h busy=%b", bus.hi, bus.lo, bus.busy);
    end
    bus.hilo_sel = 1'b0;
    #1;
    checks++;
    if (bus.hilo_rd !== 32'h1234_5678) begin
      fails++;
      $display("FAIL hilo_rd_hi got=%h want=12345678", bus.hilo_rd);
    end
    bus.hilo_sel = 1'b1;
    #1;
    checks++;
    if (bus.hilo_rd !== 32'h9ABC_DEF0) begin
      fails++;
      $display("FAIL hilo_rd_lo got=%h want=9abcdef0", bus.hilo_rd);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < 4; i++) begin
      a = $urandom;
      b = $urandom;
      sb_q.push_back(smul_model(a, b));
      run_op("rand_mult", 3'd0, a, b, MC, i[0]);
      b = $urandom_range(1, 1000);
      sb_q.push_back({a % b, a / b});
      run_op("rand_divu", 3'd3, a, b, DC, i[1]);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.op_valid = 1'b1;
    bus.md_op    = 3'd0;
    bus.rs_val   = 32'd1234;
    bus.rt_val   = 32'd5678;
    @(negedge clk);
    bus.op_valid = 1'b0;
    bus.md_op    = 3'd6;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1) begin
      fails++;
      $display("FAIL mid_busy got=%b want=1", bus.busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
      fails++;
      $display("FAIL mid_reset got busy=%b hi=%h lo=%h want 0", bus.busy, bus.hi, bus.lo);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (MC + 2) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
      fails++;
      $display("FAIL discard got busy=%b hi=%h lo=%h want 0", bus.busy, bus.hi, bus.lo);
    end
    sb_q.push_back({32'd2, 32'd14});
    run_op("divu_100_7", 3'd3, 32'd100, 32'd7, DC, 1'b0);
  endtask

  initial begin
    checks         = 0;
    fails          = 0;
    rst            = 1'b1;
    bus.op_valid   = 1'b0;
    bus.md_op      = 3'd6;
    bus.rs_val     = '0;
    bus.rt_val     = '0;
    bus.id_uses_md = 1'b0;
    bus.hilo_sel   = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_mult();
    test_div();
    test_hazard();
    test_mthi_mtlo();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_left got=%0d want=0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
